// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared BedRock message types and width helpers for the IO LCE bridge
//
// Purpose: processor-config widths, BedRock mem / LCE message-type encodings,
// the mapping constants used by the IO bridge, and a macro that declares the
// message and tracker-entry structs for a given set of widths.
// Ports: none (package).

`define DECLARE_BP_IO_LCE_BRIDGE_MSGS(paddr_w, payload_w, data_w, lce_id_w, cce_id_w) \
  typedef struct packed { \
    logic [3:0]           msg_type; \
    logic [paddr_w-1:0]   addr; \
    logic [2:0]           size; \
    logic [payload_w-1:0] payload; \
    logic [data_w-1:0]    data; \
  } bp_io_mem_msg_s; \
  typedef struct packed { \
    logic [cce_id_w-1:0]  dst_id; \
    logic [lce_id_w-1:0]  src_id; \
    logic [2:0]           lru_way_id; \
  } bp_io_lce_req_payload_s; \
  typedef struct packed { \
    logic [3:0]             msg_type; \
    logic [paddr_w-1:0]     addr; \
    logic [2:0]             size; \
    bp_io_lce_req_payload_s payload; \
    logic [data_w-1:0]      data; \
  } bp_io_lce_req_s; \
  typedef struct packed { \
    logic [lce_id_w-1:0]  dst_id; \
    logic [cce_id_w-1:0]  src_id; \
    logic [2:0]           way_id; \
  } bp_io_lce_cmd_payload_s; \
  typedef struct packed { \
    logic [3:0]             msg_type; \
    logic [paddr_w-1:0]     addr; \
    logic [2:0]             size; \
    bp_io_lce_cmd_payload_s payload; \
    logic [data_w-1:0]      data; \
  } bp_io_lce_cmd_s; \
  typedef struct packed { \
    logic                 wr_not_rd; \
    logic [paddr_w-1:0]   addr; \
    logic [2:0]           size; \
    logic [payload_w-1:0] payload; \
  } bp_io_lce_track_entry_s;

package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  typedef struct packed {
    logic [7:0] paddr_width;
    logic [7:0] data_width;
    logic [7:0] lce_id_width;
    logic [7:0] cce_id_width;
    logic [7:0] mem_payload_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_p = '{
    paddr_width       : 8'd40,
    data_width        : 8'd64,
    lce_id_width      : 8'd4,
    cce_id_width      : 8'd4,
    mem_payload_width : 8'd16
  };

  function automatic bp_proc_param_s bp_get_params(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_cfg_p;
      default:          return bp_default_cfg_p;
    endcase
  endfunction

  // msg_type(4) + addr + size(3) + payload + data
  function automatic int bp_mem_msg_width(bp_proc_param_s p);
    return 4 + int'(p.paddr_width) + 3 + int'(p.mem_payload_width) + int'(p.data_width);
  endfunction

  // LCE req and cmd share one layout; payload is {id, id, way(3)}
  function automatic int bp_lce_msg_width(bp_proc_param_s p);
    return 4 + int'(p.paddr_width) + 3
         + int'(p.lce_id_width) + int'(p.cce_id_width) + 3 + int'(p.data_width);
  endfunction

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [3:0] {
    e_bedrock_req_rd    = 4'd0,
    e_bedrock_req_wr    = 4'd1,
    e_bedrock_req_uc_rd = 4'd2,
    e_bedrock_req_uc_wr = 4'd3
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync           = 4'd0,
    e_bedrock_cmd_set_clear      = 4'd1,
    e_bedrock_cmd_transfer       = 4'd2,
    e_bedrock_cmd_writeback      = 4'd3,
    e_bedrock_cmd_set_tag        = 4'd4,
    e_bedrock_cmd_set_tag_wakeup = 4'd5,
    e_bedrock_cmd_invalidate_tag = 4'd6,
    e_bedrock_cmd_data           = 4'd7,
    e_bedrock_cmd_uc_data        = 4'd8,
    e_bedrock_cmd_uc_req_done    = 4'd9
  } bp_bedrock_cmd_type_e;

  // Everything the bridge forwards is uncached, whatever the originator asked for.
  localparam bp_bedrock_req_type_e bp_io_rd_req_type   = e_bedrock_req_uc_rd;
  localparam bp_bedrock_req_type_e bp_io_wr_req_type   = e_bedrock_req_uc_wr;
  localparam bp_bedrock_cmd_type_e bp_io_rd_cmd_type   = e_bedrock_cmd_uc_data;
  localparam bp_bedrock_cmd_type_e bp_io_wr_cmd_type   = e_bedrock_cmd_uc_req_done;
  localparam bp_bedrock_mem_type_e bp_io_rd_resp_type  = e_bedrock_mem_uc_rd;
  localparam bp_bedrock_mem_type_e bp_io_wr_resp_type  = e_bedrock_mem_uc_wr;

endpackage

// File: rtl/bp_io_lce_bridge_tracker.sv
// rtl/bp_io_lce_bridge_tracker.sv - in-order outstanding-request tracker (1r1w FIFO)
//
// Purpose: holds one entry per in-flight uncached request so the response can
// be rebuilt with the originator's fields.
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   push_i, data_i        enqueue (ignored while full)
//   pop_i,  data_o        dequeue (ignored while empty), head entry
//   full_o, empty_o       occupancy flags
//   count_o               occupancy 0..els_p

module bp_io_lce_bridge_tracker
  #(parameter int width_p = 1
   ,parameter int els_p   = 4
   ,localparam int ptr_width_lp   = $clog2(els_p)
   ,localparam int count_width_lp = $clog2(els_p + 1)
   )
  (input  logic                      clk_i
  ,input  logic                      reset_n_i
  ,input  logic                      push_i
  ,input  logic [width_p-1:0]        data_i
  ,input  logic                      pop_i
  ,output logic [width_p-1:0]        data_o
  ,output logic                      full_o
  ,output logic                      empty_o
  ,output logic [count_width_lp-1:0] count_o
  );

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      do_push, do_pop;

  assign full_o  = (count_r == count_width_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign count_o = count_r;
  assign data_o  = mem_r[rptr_r];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_r[wptr_r] <= data_i;
  end

  // els_p is a power of 2, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wptr_r <= wptr_r + ptr_width_lp'(1);
      if (do_pop)  rptr_r <= rptr_r + ptr_width_lp'(1);
      if (do_push & ~do_pop)      count_r <= count_r + count_width_lp'(1);
      else if (do_pop & ~do_push) count_r <= count_r - count_width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_io_lce_bridge.sv
// rtl/bp_io_lce_bridge.sv - inbound IO-link to LCE uncached-request bridge
//
// Purpose: turns BedRock mem commands from the IO link into uncached LCE
// requests, and the CCE's uc_data / uc_req_done returns into mem responses.
// Ports:
//   clk_i, reset_n_i                         clock, asynchronous active-low reset
//   lce_id_i, cce_dst_id_i                   src/dst ids stamped on requests
//   io_cmd_i, io_cmd_v_i, io_cmd_yumi_o      inbound mem command
//   lce_req_o, lce_req_v_o, lce_req_ready_i  uncached LCE request
//   lce_cmd_i, lce_cmd_v_i, lce_cmd_yumi_o   LCE command from the CCE
//   io_resp_o, io_resp_v_o, io_resp_ready_i  mem response to the link
//   outstanding_o                            tracker occupancy
//   err_o                                    sticky protocol error

module bp_io_lce_bridge
  import bp_me_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,parameter int els_p = 4
   ,localparam bp_proc_param_s proc_param_lp = bp_get_params(bp_params_p)
   ,localparam int paddr_width_lp       = int'(proc_param_lp.paddr_width)
   ,localparam int data_width_lp        = int'(proc_param_lp.data_width)
   ,localparam int lce_id_width_lp      = int'(proc_param_lp.lce_id_width)
   ,localparam int cce_id_width_lp      = int'(proc_param_lp.cce_id_width)
   ,localparam int mem_payload_width_lp = int'(proc_param_lp.mem_payload_width)
   ,localparam int cce_mem_msg_width_lp = bp_mem_msg_width(proc_param_lp)
   ,localparam int lce_req_msg_width_lp = bp_lce_msg_width(proc_param_lp)
   ,localparam int lce_cmd_msg_width_lp = bp_lce_msg_width(proc_param_lp)
   ,localparam int count_width_lp       = $clog2(els_p + 1)
   )
  (input  logic                            clk_i
  ,input  logic                            reset_n_i
  ,input  logic [lce_id_width_lp-1:0]      lce_id_i
  ,input  logic [cce_id_width_lp-1:0]      cce_dst_id_i
  ,input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
  ,input  logic                            io_cmd_v_i
  ,output logic                            io_cmd_yumi_o
  ,output logic [lce_req_msg_width_lp-1:0] lce_req_o
  ,output logic                            lce_req_v_o
  ,input  logic                            lce_req_ready_i
  ,input  logic [lce_cmd_msg_width_lp-1:0] lce_cmd_i
  ,input  logic                            lce_cmd_v_i
  ,output logic                            lce_cmd_yumi_o
  ,output logic [cce_mem_msg_width_lp-1:0] io_resp_o
  ,output logic                            io_resp_v_o
  ,input  logic                            io_resp_ready_i
  ,output logic [count_width_lp-1:0]       outstanding_o
  ,output logic                            err_o
  );

  `DECLARE_BP_IO_LCE_BRIDGE_MSGS(paddr_width_lp, mem_payload_width_lp, data_width_lp, lce_id_width_lp, cce_id_width_lp)

  localparam int entry_width_lp = $bits(bp_io_lce_track_entry_s);

  bp_io_mem_msg_s         io_cmd, io_resp;
  bp_io_lce_req_s         lce_req;
  bp_io_lce_cmd_s         lce_cmd;
  bp_io_lce_track_entry_s push_entry, head_entry;
  logic [entry_width_lp-1:0] head_entry_raw;

  logic cmd_supported, cmd_wr;
  logic accept, reject;
  logic pop, drain, mismatch;
  logic full, empty;
  logic err_r;

  assign io_cmd  = io_cmd_i;
  assign lce_cmd = lce_cmd_i;

  // ---------------- request path ----------------
  always_comb begin
    cmd_supported = 1'b0;
    cmd_wr        = 1'b0;
    case (io_cmd.msg_type)
      e_bedrock_mem_rd, e_bedrock_mem_uc_rd: cmd_supported = 1'b1;
      e_bedrock_mem_wr, e_bedrock_mem_uc_wr: begin
        cmd_supported = 1'b1;
        cmd_wr        = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshakes are gated by reset so nothing is acknowledged while held in reset.
  assign accept = reset_n_i & io_cmd_v_i & cmd_supported & ~full & lce_req_ready_i;
  // Unsupported commands are swallowed so the link never deadlocks on them.
  assign reject = reset_n_i & io_cmd_v_i & ~cmd_supported;

  assign io_cmd_yumi_o = accept | reject;
  assign lce_req_v_o   = accept;

  always_comb begin
    lce_req                = '0;
    lce_req.msg_type       = cmd_wr ? bp_io_wr_req_type : bp_io_rd_req_type;
    lce_req.addr           = io_cmd.addr;
    lce_req.size           = io_cmd.size;
    lce_req.data           = io_cmd.data;
    lce_req.payload.src_id = lce_id_i;
    lce_req.payload.dst_id = cce_dst_id_i;
  end
  assign lce_req_o = lce_req;

  always_comb begin
    push_entry           = '0;
    push_entry.wr_not_rd = cmd_wr;
    push_entry.addr      = io_cmd.addr;
    push_entry.size      = io_cmd.size;
    push_entry.payload   = io_cmd.payload;
  end

  // ---------------- tracker ----------------
  bp_io_lce_bridge_tracker
    #(.width_p(entry_width_lp)
     ,.els_p  (els_p)
     )
    tracker
     (.clk_i    (clk_i)
     ,.reset_n_i(reset_n_i)
     ,.push_i   (accept)
     ,.data_i   (push_entry)
     ,.pop_i    (pop)
     ,.data_o   (head_entry_raw)
     ,.full_o   (full)
     ,.empty_o  (empty)
     ,.count_o  (outstanding_o)
     );

  assign head_entry = head_entry_raw;

  // ---------------- response path ----------------
  assign pop   = reset_n_i & lce_cmd_v_i & ~empty & io_resp_ready_i;
  // A return with nothing outstanding has no owner: drop it and flag it.
  assign drain = reset_n_i & lce_cmd_v_i & empty;

  assign lce_cmd_yumi_o = pop | drain;
  assign io_resp_v_o    = pop;

  assign mismatch = (lce_cmd.msg_type != (head_entry.wr_not_rd ? bp_io_wr_cmd_type : bp_io_rd_cmd_type))
                  | (lce_cmd.addr != head_entry.addr);

  always_comb begin
    io_resp          = '0;
    io_resp.msg_type = head_entry.wr_not_rd ? bp_io_wr_resp_type : bp_io_rd_resp_type;
    io_resp.addr     = head_entry.addr;
    io_resp.size     = head_entry.size;
    io_resp.payload  = head_entry.payload;
    io_resp.data     = head_entry.wr_not_rd ? '0 : lce_cmd.data;
  end
  assign io_resp_o = io_resp;

  // ---------------- sticky error ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_r <= 1'b0;
    else if (reject | drain | (pop & mismatch)) err_r <= 1'b1;
  end
  assign err_o = err_r;

  // The CCE's size and routing payload carry nothing the link response needs.
  logic unused_lce_cmd_fields;
  assign unused_lce_cmd_fields = ^{lce_cmd.size, lce_cmd.payload};

endmodule

// File: tb/tb_bp_io_lce_bridge.sv
// tb/tb_bp_io_lce_bridge.sv - self-checking bench for bp_io_lce_bridge

module tb_bp_io_lce_bridge;
  import bp_me_pkg::*;

  localparam int els_lp  = 4;
  localparam int paddr_w = int'(bp_default_cfg_p.paddr_width);
  localparam int data_w  = int'(bp_default_cfg_p.data_width);
  localparam int lid_w   = int'(bp_default_cfg_p.lce_id_width);
  localparam int cid_w   = int'(bp_default_cfg_p.cce_id_width);
  localparam int pay_w   = int'(bp_default_cfg_p.mem_payload_width);
  localparam int mem_w   = bp_mem_msg_width(bp_default_cfg_p);
  localparam int lce_w   = bp_lce_msg_width(bp_default_cfg_p);
  localparam int cnt_w   = $clog2(els_lp + 1);

  `DECLARE_BP_IO_LCE_BRIDGE_MSGS(paddr_w, pay_w, data_w, lid_w, cid_w)

  logic clk, reset_n_i;
  logic [lid_w-1:0] lce_id_i;
  logic [cid_w-1:0] cce_dst_id_i;
  logic [mem_w-1:0] io_cmd_i, io_resp_o;
  logic [lce_w-1:0] lce_req_o, lce_cmd_i;
  logic io_cmd_v_i, io_cmd_yumi_o, lce_req_v_o, lce_req_ready_i;
  logic lce_cmd_v_i, lce_cmd_yumi_o, io_resp_v_o, io_resp_ready_i, err_o;
  logic [cnt_w-1:0] outstanding_o;

  bp_io_lce_bridge #(.bp_params_p(e_bp_default_cfg), .els_p(els_lp)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i), .cce_dst_id_i(cce_dst_id_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
    .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i),
    .lce_cmd_i(lce_cmd_i), .lce_cmd_v_i(lce_cmd_v_i), .lce_cmd_yumi_o(lce_cmd_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
    .outstanding_o(outstanding_o), .err_o(err_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain in-order list of what the link asked for.
  typedef struct {
    logic               wr;
    logic [paddr_w-1:0] addr;
    logic [2:0]         size;
    logic [pay_w-1:0]   payload;
  } ref_t;
  ref_t model_q[$];

  int checks = 0;
  int passes = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io_cmd_v_i  = 1'b0;
    lce_cmd_v_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    model_q.delete();
  endtask

  task automatic drive_cmd(input logic [3:0] t, input ref_t e, input logic [data_w-1:0] d);
    bp_io_mem_msg_s m;
    m.msg_type = t; m.addr = e.addr; m.size = e.size; m.payload = e.payload; m.data = d;
    io_cmd_i   = m;
    io_cmd_v_i = 1'b1;
  endtask

  task automatic drive_lce_cmd(input logic [3:0] t, input logic [paddr_w-1:0] a, input logic [data_w-1:0] d);
    bp_io_lce_cmd_s c;
    c = '0;
    c.msg_type = t; c.addr = a; c.data = d;
    c.size = 3'($urandom); c.payload.way_id = 3'($urandom);
    lce_cmd_i   = c;
    lce_cmd_v_i = 1'b1;
  endtask

  task automatic drive_rand_cmd(output ref_t e, output logic [data_w-1:0] d);
    logic [3:0]  t;
    logic [63:0] a;
    t = 4'($urandom_range(0, 3));
    a = {$urandom, $urandom};
    e.wr      = (t == 4'd1) || (t == 4'd3);
    e.addr    = a[paddr_w-1:0];
    e.size    = 3'($urandom_range(0, 7));
    e.payload = pay_w'($urandom);
    d         = {$urandom, $urandom};
    drive_cmd(t, e, d);
  endtask

  // rd/uc_rd -> uc_rd(2), wr/uc_wr -> uc_wr(3); ids from the side inputs; rest zero.
  function automatic logic [lce_w-1:0] exp_req(input ref_t e, input logic [data_w-1:0] d);
    bp_io_lce_req_s r;
    r = '0;
    r.msg_type = e.wr ? 4'd3 : 4'd2;
    r.addr = e.addr; r.size = e.size; r.data = d;
    r.payload.src_id = lce_id_i;
    r.payload.dst_id = cce_dst_id_i;
    return r;
  endfunction

  function automatic logic [mem_w-1:0] exp_resp(input ref_t e, input logic [data_w-1:0] cd);
    bp_io_mem_msg_s m;
    m.msg_type = e.wr ? 4'd3 : 4'd2;
    m.addr = e.addr; m.size = e.size; m.payload = e.payload;
    m.data = e.wr ? '0 : cd;
    return m;
  endfunction

  function automatic logic [3:0] reply_type(input ref_t e);
    return e.wr ? 4'd9 : 4'd8;
  endfunction

  task automatic test_reset();
    ref_t e;
    logic [data_w-1:0] d;
    reset_n_i = 1'b0;
    lce_id_i = '0; cce_dst_id_i = '0; lce_req_ready_i = 1'b1; io_resp_ready_i = 1'b1;
    lce_cmd_i = '0;
    drive_rand_cmd(e, d);
    drive_lce_cmd(4'd8, '0, '0);
    #2;
    checks++; if (io_cmd_yumi_o !== 1'b0) $display("FAIL reset_io_cmd_yumi: got %b want 0", io_cmd_yumi_o); else passes++;
    checks++; if (lce_req_v_o !== 1'b0) $display("FAIL reset_lce_req_v: got %b want 0", lce_req_v_o); else passes++;
    checks++; if (lce_cmd_yumi_o !== 1'b0) $display("FAIL reset_lce_cmd_yumi: got %b want 0", lce_cmd_yumi_o); else passes++;
    checks++; if (io_resp_v_o !== 1'b0) $display("FAIL reset_io_resp_v: got %b want 0", io_resp_v_o); else passes++;
    checks++; if (outstanding_o !== '0) $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passes++;
    apply_reset();
  endtask

  task automatic test_uc_read();
    ref_t e;
    logic [data_w-1:0] d;
    apply_reset();
    lce_id_i = 4'd2; cce_dst_id_i = cid_w'($urandom);
    e.wr = 1'b0; e.addr = 40'h00_8000_0040; e.size = 3'd3; e.payload = pay_w'($urandom);
    d = {$urandom, $urandom};
    drive_cmd(4'd2, e, d);
    #1;
    checks++; if (io_cmd_yumi_o !== 1'b1) $display("FAIL rd_yumi: got %b want 1", io_cmd_yumi_o); else passes++;
    checks++; if (lce_req_v_o !== 1'b1) $display("FAIL rd_req_v: got %b want 1", lce_req_v_o); else passes++;
    checks++; if (lce_req_o !== exp_req(e, d)) $display("FAIL rd_req: got %h want %h", lce_req_o, exp_req(e, d)); else passes++;
    tick(); idle();
    checks++; if (outstanding_o !== cnt_w'(1)) $display("FAIL rd_outstanding: got %0d want 1", outstanding_o); else passes++;
    drive_lce_cmd(4'd8, e.addr, 64'hDEAD_BEEF);
    #1;
    checks++; if (io_resp_v_o !== 1'b1 || lce_cmd_yumi_o !== 1'b1) $display("FAIL rd_resp_hs: got v=%b yumi=%b want 1/1", io_resp_v_o, lce_cmd_yumi_o); else passes++;
    checks++; if (io_resp_o !== exp_resp(e, 64'hDEAD_BEEF)) $display("FAIL rd_resp: got %h want %h", io_resp_o, exp_resp(e, 64'hDEAD_BEEF)); else passes++;
    tick(); idle();
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) $display("FAIL rd_done: got occ=%0d err=%b want 0/0", outstanding_o, err_o); else passes++;
  endtask

  task automatic test_uc_write();
    ref_t e;
    logic [data_w-1:0] cd;
    apply_reset();
    e.wr = 1'b1; e.addr = paddr_w'({$urandom, $urandom}); e.size = 3'd0; e.payload = pay_w'($urandom);
    lce_req_ready_i = 1'b0;
    drive_cmd(4'd3, e, 64'h55);
    #1;
    checks++; if (io_cmd_yumi_o !== 1'b0 || lce_req_v_o !== 1'b0) $display("FAIL wr_not_ready: got yumi=%b v=%b want 0/0", io_cmd_yumi_o, lce_req_v_o); else passes++;
    lce_req_ready_i = 1'b1;
    #1;
    checks++; if (lce_req_v_o !== 1'b1 || lce_req_o !== exp_req(e, 64'h55)) $display("FAIL wr_req: got v=%b %h want 1 %h", lce_req_v_o, lce_req_o, exp_req(e, 64'h55)); else passes++;
    tick(); idle();
    cd = {$urandom, $urandom} | 64'h1;
    io_resp_ready_i = 1'b0;
    drive_lce_cmd(4'd9, e.addr, cd);
    #1;
    checks++; if (io_resp_v_o !== 1'b0 || lce_cmd_yumi_o !== 1'b0) $display("FAIL wr_resp_stall: got v=%b yumi=%b want 0/0", io_resp_v_o, lce_cmd_yumi_o); else passes++;
    io_resp_ready_i = 1'b1;
    #1;
    checks++; if (io_resp_v_o !== 1'b1 || io_resp_o !== exp_resp(e, cd)) $display("FAIL wr_resp: got v=%b %h want 1 %h", io_resp_v_o, io_resp_o, exp_resp(e, cd)); else passes++;
    tick(); idle();
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) $display("FAIL wr_done: got occ=%0d err=%b want 0/0", outstanding_o, err_o); else passes++;
  endtask

  task automatic test_full();
    ref_t e, e5;
    logic [data_w-1:0] d, d5, cd;
    apply_reset();
    for (int i = 0; i < els_lp; i++) begin
      drive_rand_cmd(e, d);
      #1;
      checks++; if (io_cmd_yumi_o !== 1'b1) $display("FAIL full_fill%0d: got yumi=%b want 1", i, io_cmd_yumi_o); else passes++;
      model_q.push_back(e);
      tick();
    end
    drive_rand_cmd(e5, d5);
    #1;
    checks++; if (io_cmd_yumi_o !== 1'b0 || lce_req_v_o !== 1'b0) $display("FAIL full_stall: got yumi=%b v=%b want 0/0", io_cmd_yumi_o, lce_req_v_o); else passes++;
    checks++; if (outstanding_o !== cnt_w'(els_lp)) $display("FAIL full_occ: got %0d want %0d", outstanding_o, els_lp); else passes++;
    tick();
    cd = {$urandom, $urandom};
    drive_lce_cmd(reply_type(model_q[0]), model_q[0].addr, cd);
    #1;
    checks++; if (io_resp_v_o !== 1'b1 || io_resp_o !== exp_resp(model_q[0], cd)) $display("FAIL full_pop: got v=%b %h want 1 %h", io_resp_v_o, io_resp_o, exp_resp(model_q[0], cd)); else passes++;
    checks++; if (io_cmd_yumi_o !== 1'b0) $display("FAIL full_no_bypass: got yumi=%b want 0", io_cmd_yumi_o); else passes++;
    void'(model_q.pop_front());
    tick();
    lce_cmd_v_i = 1'b0;
    #1;
    checks++; if (io_cmd_yumi_o !== 1'b1 || lce_req_o !== exp_req(e5, d5)) $display("FAIL full_fifth: got yumi=%b %h want 1 %h", io_cmd_yumi_o, lce_req_o, exp_req(e5, d5)); else passes++;
    model_q.push_back(e5);
    tick(); idle();
    checks++; if (outstanding_o !== cnt_w'(els_lp)) $display("FAIL full_refill: got %0d want %0d", outstanding_o, els_lp); else passes++;
    while (model_q.size() > 0) begin
      cd = {$urandom, $urandom};
      drive_lce_cmd(reply_type(model_q[0]), model_q[0].addr, cd);
      #1;
      checks++; if (io_resp_v_o !== 1'b1 || io_resp_o !== exp_resp(model_q[0], cd)) $display("FAIL full_drain: got v=%b %h want 1 %h", io_resp_v_o, io_resp_o, exp_resp(model_q[0], cd)); else passes++;
      void'(model_q.pop_front());
      tick();
    end
    idle();
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) $display("FAIL full_end: got occ=%0d err=%b want 0/0", outstanding_o, err_o); else passes++;
  endtask

  task automatic test_back_to_back();
    ref_t e;
    logic [data_w-1:0] d, cd;
    apply_reset();
    drive_rand_cmd(e, d);
    model_q.push_back(e);
    tick();
    for (int i = 0; i < 20; i++) begin
      cd = {$urandom, $urandom};
      drive_lce_cmd(reply_type(model_q[0]), model_q[0].addr, cd);
      drive_rand_cmd(e, d);
      #1;
      checks++; if (io_resp_v_o !== 1'b1 || io_resp_o !== exp_resp(model_q[0], cd)) $display("FAIL b2b_resp%0d: got v=%b %h want 1 %h", i, io_resp_v_o, io_resp_o, exp_resp(model_q[0], cd)); else passes++;
      checks++; if (io_cmd_yumi_o !== 1'b1 || lce_req_o !== exp_req(e, d)) $display("FAIL b2b_req%0d: got yumi=%b %h want 1 %h", i, io_cmd_yumi_o, lce_req_o, exp_req(e, d)); else passes++;
      void'(model_q.pop_front());
      model_q.push_back(e);
      tick();
      checks++; if (outstanding_o !== cnt_w'(1)) $display("FAIL b2b_occ%0d: got %0d want 1", i, outstanding_o); else passes++;
    end
    idle();
    cd = {$urandom, $urandom};
    drive_lce_cmd(reply_type(model_q[0]), model_q[0].addr, cd);
    #1;
    checks++; if (io_resp_o !== exp_resp(model_q[0], cd)) $display("FAIL b2b_last: got %h want %h", io_resp_o, exp_resp(model_q[0], cd)); else passes++;
    void'(model_q.pop_front());
    tick(); idle();
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) $display("FAIL b2b_end: got occ=%0d err=%b want 0/0", outstanding_o, err_o); else passes++;
  endtask

  task automatic test_errors();
    ref_t e;
    logic [data_w-1:0] d, cd;
    apply_reset();
    e.wr = 1'b0; e.addr = paddr_w'({$urandom, $urandom}); e.size = 3'd2; e.payload = pay_w'($urandom);
    drive_cmd(4'd4, e, '0);
    #1;
    checks++; if (io_cmd_yumi_o !== 1'b1 || lce_req_v_o !== 1'b0) $display("FAIL unsup_hs: got yumi=%b v=%b want 1/0", io_cmd_yumi_o, lce_req_v_o); else passes++;
    tick(); idle();
    checks++; if (err_o !== 1'b1 || outstanding_o !== '0) $display("FAIL unsup_err: got err=%b occ=%0d want 1/0", err_o, outstanding_o); else passes++;
    apply_reset();
    checks++; if (err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o); else passes++;
    drive_lce_cmd(4'd8, e.addr, '0);
    #1;
    checks++; if (lce_cmd_yumi_o !== 1'b1 || io_resp_v_o !== 1'b0) $display("FAIL empty_hs: got yumi=%b v=%b want 1/0", lce_cmd_yumi_o, io_resp_v_o); else passes++;
    tick(); idle();
    checks++; if (err_o !== 1'b1) $display("FAIL empty_err: got %b want 1", err_o); else passes++;
    apply_reset();
    d = {$urandom, $urandom};
    drive_cmd(4'd0, e, d);
    tick(); idle();
    cd = {$urandom, $urandom};
    drive_lce_cmd(4'd9, e.addr, cd);
    #1;
    checks++; if (io_resp_v_o !== 1'b1 || io_resp_o !== exp_resp(e, cd)) $display("FAIL badtype_resp: got v=%b %h want 1 %h", io_resp_v_o, io_resp_o, exp_resp(e, cd)); else passes++;
    tick(); idle();
    checks++; if (err_o !== 1'b1 || outstanding_o !== '0) $display("FAIL badtype_err: got err=%b occ=%0d want 1/0", err_o, outstanding_o); else passes++;
    apply_reset();
    e.wr = 1'b1;
    drive_cmd(4'd1, e, d);
    tick(); idle();
    drive_lce_cmd(4'd9, e.addr ^ paddr_w'(64), cd);
    #1;
    checks++; if (io_resp_v_o !== 1'b1) $display("FAIL badaddr_resp: got v=%b want 1", io_resp_v_o); else passes++;
    tick(); idle();
    checks++; if (err_o !== 1'b1) $display("FAIL badaddr_err: got %b want 1", err_o); else passes++;
  endtask

  task automatic test_reset_midflight();
    ref_t e;
    logic [data_w-1:0] d;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_rand_cmd(e, d);
      tick();
    end
    drive_rand_cmd(e, d);
    drive_lce_cmd(4'd8, e.addr, d);
    #1;
    reset_n_i = 1'b0;
    #1;
    checks++; if ({io_cmd_yumi_o, lce_req_v_o, lce_cmd_yumi_o, io_resp_v_o} !== 4'b0) $display("FAIL mid_outputs: got %b want 0000", {io_cmd_yumi_o, lce_req_v_o, lce_cmd_yumi_o, io_resp_v_o}); else passes++;
    checks++; if (outstanding_o !== '0) $display("FAIL mid_occ: got %0d want 0", outstanding_o); else passes++;
    tick(); idle();
    reset_n_i = 1'b1;
    #1;
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) $display("FAIL mid_release: got occ=%0d err=%b want 0/0", outstanding_o, err_o); else passes++;
    drive_lce_cmd(4'd8, e.addr, d);
    #1;
    checks++; if (lce_cmd_yumi_o !== 1'b1 || io_resp_v_o !== 1'b0) $display("FAIL mid_late_cmd: got yumi=%b v=%b want 1/0", lce_cmd_yumi_o, io_resp_v_o); else passes++;
    tick(); idle();
    checks++; if (err_o !== 1'b1) $display("FAIL mid_late_err: got %b want 1", err_o); else passes++;
  endtask

  initial begin
    test_reset();
    test_uc_read();
    test_uc_write();
    test_full();
    test_back_to_back();
    test_errors();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
